// File: rtl/mod_n_counter_sched.sv
// Round-robin job scheduler in front of a shared up/down mod-N counter.
// Two requesters each submit {direction, step count}. The winner gets the
// counter's enable/direction for exactly that many cycles, then receives a
// one-cycle done pulse and the counter value captured on completion.
module mod_n_counter_sched #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned N     = 3,
   parameter int unsigned LEN_W = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [1:0]         i_req_valid,
   input  logic [1:0]         i_req_dir,
   input  logic [2*LEN_W-1:0] i_req_len,
   output logic [1:0]         o_req_ready,
   output logic [1:0]         o_done,
   output logic               o_busy,
   output logic               o_grant_id,
   output logic               o_cnt_en,
   output logic               o_cnt_up_down,
   input  logic [WIDTH-1:0]   i_cnt_q,
   output logic [WIDTH-1:0]   o_final_q
);

   // N only describes the attached counter; reject a modulus the value width cannot hold.
   if (N < 2 || N > (1 << WIDTH)) begin : g_bad_n
      $error("mod_n_counter_sched: N does not fit in WIDTH bits");
   end

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e             r_state;
   state_e             w_state_next;

   logic               r_dir;
   logic               r_id;
   logic               r_last_grant;
   logic [LEN_W-1:0]   r_rem;
   logic [WIDTH-1:0]   r_final_q;

   logic               w_winner;
   logic               w_any_valid;
   logic               w_accept;
   logic               w_sel_dir;
   logic [LEN_W-1:0]   w_sel_len;
   logic               w_last_step;

   // Arbitration: a lone requester wins; on contention the one not served last wins.
   always_comb begin
      w_any_valid = |i_req_valid;
      if (i_req_valid == 2'b11) begin
         w_winner = ~r_last_grant;
      end else begin
         w_winner = i_req_valid[1];
      end
      w_sel_dir = w_winner ? i_req_dir[1] : i_req_dir[0];
      w_sel_len = w_winner ? i_req_len[LEN_W +: LEN_W] : i_req_len[0 +: LEN_W];
   end

   // Ready is offered only in IDLE; masked by reset so every output reads 0 while held in reset.
   always_comb begin
      o_req_ready = 2'b00;
      if (r_state == StIdle && w_any_valid && i_rst_n) begin
         o_req_ready = w_winner ? 2'b10 : 2'b01;
      end
      w_accept    = |(i_req_valid & o_req_ready);
      w_last_step = (r_rem == LEN_W'(1));
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a zero-length job skips RUN entirely.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_next = (w_sel_len != '0) ? StRun : StDone;
            end
         end
         StRun: begin
            if (w_last_step) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Job datapath: latch on handshake, count down in RUN, close out in DONE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dir        <= 1'b0;
         r_id         <= 1'b0;
         r_rem        <= '0;
         r_last_grant <= 1'b1;
         r_final_q    <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_dir <= w_sel_dir;
                  r_id  <= w_winner;
                  r_rem <= w_sel_len;
               end
            end
            StRun: begin
               r_rem <= r_rem - LEN_W'(1);
            end
            StDone: begin
               r_final_q    <= i_cnt_q;
               r_last_grant <= r_id;
            end
            default: begin
               r_rem <= '0;
            end
         endcase
      end
   end

   // Outputs decoded from registered state only, so reset drops o_cnt_en immediately.
   always_comb begin
      o_cnt_en      = 1'b0;
      o_cnt_up_down = 1'b0;
      o_done        = 2'b00;
      o_busy        = (r_state != StIdle);
      o_grant_id    = r_id;
      o_final_q     = r_final_q;
      unique case (r_state)
         StRun: begin
            o_cnt_en      = 1'b1;
            o_cnt_up_down = r_dir;
         end
         StDone: begin
            o_done = r_id ? 2'b10 : 2'b01;
         end
         default: begin
            o_cnt_en = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mod_n_counter_sched.sv
// Directed bench for mod_n_counter_sched with a behavioural mod-N counter in the loop.
module tb_mod_n_counter_sched;

   localparam int unsigned WIDTH = 2;
   localparam int unsigned N     = 3;
   localparam int unsigned LEN_W = 4;

   logic               clk;
   logic               rst_n;
   logic [1:0]         req_valid;
   logic [1:0]         req_dir;
   logic [2*LEN_W-1:0] req_len;
   logic [1:0]         req_ready;
   logic [1:0]         done;
   logic               busy;
   logic               grant_id;
   logic               cnt_en;
   logic               cnt_up_down;
   logic [WIDTH-1:0]   cnt_q;
   logic [WIDTH-1:0]   final_q;

   int total = 0;
   int bad   = 0;

   mod_n_counter_sched #(
      .WIDTH(WIDTH),
      .N    (N),
      .LEN_W(LEN_W)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .i_req_dir    (req_dir),
      .i_req_len    (req_len),
      .o_req_ready  (req_ready),
      .o_done       (done),
      .o_busy       (busy),
      .o_grant_id   (grant_id),
      .o_cnt_en     (cnt_en),
      .o_cnt_up_down(cnt_up_down),
      .i_cnt_q      (cnt_q),
      .o_final_q    (final_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stand-in for the shared mod-N up/down counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_en) begin
         if (cnt_up_down) cnt_q <= (cnt_q == WIDTH'(N - 1)) ? '0 : cnt_q + 1'b1;
         else             cnt_q <= (cnt_q == '0) ? WIDTH'(N - 1) : cnt_q - 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One solo job from requester id; checks handshake, RUN length, done pulse, final value.
   task automatic do_job(input int id, input logic dir, input int len, input int exp_final);
      req_valid = 2'b00;
      req_valid[id] = 1'b1;
      req_dir[id] = dir;
      req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
      #1;
      chk($sformatf("ready_job%0d", id), 32'(req_ready), 32'(2'b01 << id));
      tick();
      req_valid = 2'b00;
      chk("grant_id_at_accept", 32'(grant_id), 32'(id));
      for (int k = 1; k <= len; k++) begin
         chk($sformatf("run_en_c%0d", k), 32'(cnt_en), 32'd1);
         chk($sformatf("run_dir_c%0d", k), 32'(cnt_up_down), 32'(dir));
         tick();
      end
      chk("done_pulse", 32'(done), 32'(2'b01 << id));
      chk("done_en_low", 32'(cnt_en), 32'd0);
      chk("done_dir_low", 32'(cnt_up_down), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      tick();
      chk("final_q", 32'(final_q), 32'(exp_final));
      chk("done_cleared", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("grant_id_after", 32'(grant_id), 32'(id));
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_dir   = 2'b00;
      req_len   = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_en", 32'(cnt_en), 32'd0);
      chk("rst_final", 32'(final_q), 32'd0);
      rst_n = 1'b1;
      tick();

      // Up 4 from 0: 0->1->2->0->1.
      do_job(0, 1'b1, 4, 1);
      tick();
      // Down 2 from 1: 1->0->2.
      do_job(1, 1'b0, 2, 2);
      tick();
      // Zero-length job: no enable, done next cycle, captures current value 2.
      do_job(0, 1'b1, 0, 2);
      tick();

      // req1 up 3 from 2 (2->0->1->2); req0 pulses once while busy and is dropped.
      req_valid = 2'b10;
      req_dir   = 2'b10;
      req_len   = {LEN_W'(3), LEN_W'(0)};
      #1;
      chk("busy_ready1", 32'(req_ready), 32'b10);
      tick();
      req_valid = 2'b01;
      #1;
      chk("busy_ignore_ready", 32'(req_ready), 32'd0);
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      chk("busy_done_owner", 32'(done), 32'b10);
      tick();
      chk("busy_final", 32'(final_q), 32'd2);
      chk("busy_no_late_ready", 32'(req_ready), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);

      // Reset, then both valid together: req0 first, req1 next, then req0 again.
      rst_n = 1'b0;
      #1;
      chk("rst2_final", 32'(final_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      req_valid = 2'b11;
      req_dir   = 2'b01;
      req_len   = {LEN_W'(1), LEN_W'(1)};
      #1;
      chk("rr_first", 32'(req_ready), 32'b01);
      tick();
      chk("rr_run_en", 32'(cnt_en), 32'd1);
      chk("rr_run_ready", 32'(req_ready), 32'd0);
      chk("rr_run_grant", 32'(grant_id), 32'd0);
      tick();
      chk("rr_done0", 32'(done), 32'b01);
      chk("rr_done_ready", 32'(req_ready), 32'd0);
      tick();
      chk("rr_final0", 32'(final_q), 32'd1);
      chk("rr_second", 32'(req_ready), 32'b10);
      tick();
      chk("rr_run1_dir", 32'(cnt_up_down), 32'd0);
      chk("rr_run1_grant", 32'(grant_id), 32'd1);
      tick();
      chk("rr_done1", 32'(done), 32'b10);
      tick();
      chk("rr_final1", 32'(final_q), 32'd0);
      chk("rr_third", 32'(req_ready), 32'b01);
      req_valid = 2'b00;
      tick();

      // Reset during the 2nd RUN cycle of a len=5 job.
      req_valid = 2'b01;
      req_dir   = 2'b01;
      req_len   = {LEN_W'(0), LEN_W'(5)};
      #1;
      chk("abort_ready", 32'(req_ready), 32'b01);
      tick();
      req_valid = 2'b00;
      tick();
      chk("abort_pre_en", 32'(cnt_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_en", 32'(cnt_en), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_final", 32'(final_q), 32'd0);
      chk("abort_grant", 32'(grant_id), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_job(1, 1'b1, 1, 1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
